mem_req_arbiter: RTL and testbench
==================================

MEM_REQ_ARBITER -- requirements
Module: mem_req_arbiter

Interface
REQ-001 Parameter NUM_REQ, default 4, number of requesters sharing one DRAM request queue.
REQ-002 Parameter ADDR_WIDTH, default 32, request address width.
REQ-003 Parameter DATA_WIDTH, default 512, write/read data width.
REQ-004 Parameter MAX_OUTSTANDING, default 8, read credits per requester.
REQ-005 clk  input  1  clock.
REQ-006 reset  input  1  synchronous, active-high reset.
REQ-007 start  input  1  pulse; leaves IDLE and starts a new job, clearing all credit counters.
REQ-008 drain  input  1  pulse; stops new grants until all reads return.
REQ-009 req_valid  input  NUM_REQ  per-requester request valid.
REQ-010 req_we  input  NUM_REQ  per-requester write flag (1 = write, 0 = read).
REQ-011 req_addr  input  NUM_REQ*ADDR_WIDTH  per-requester address, packed with requester 0 in the LSBs.
REQ-012 req_wdata  input  NUM_REQ*DATA_WIDTH  per-requester write data, packed with requester 0 in the LSBs.
REQ-013 req_ready  output  NUM_REQ  grant; the request transfers when valid and ready are both high.
REQ-014 q_enq  output  1  enqueue strobe to the downstream request queue.
REQ-015 q_data  output  $clog2(NUM_REQ)+1+ADDR_WIDTH+DATA_WIDTH  packed fields {id, we, addr, wdata}.
REQ-016 q_full  input  1  downstream queue full.
REQ-017 rsp_in_valid  input  1  read response from DRAM.
REQ-018 rsp_in_id  input  $clog2(NUM_REQ)  requester id of the response.
REQ-019 rsp_in_data  input  DATA_WIDTH  response data.
REQ-020 rsp_valid  output  NUM_REQ  one-hot response strobe.
REQ-021 rsp_data  output  DATA_WIDTH  response data.
REQ-022 busy  output  1  state is not IDLE.
REQ-023 drain_done  output  1  one-cycle pulse when DRAIN completes.
REQ-024 err  output  1  sticky flag for a response with no outstanding read.

Function
REQ-025 The FSM SHALL have three states: IDLE, RUN and DRAIN.
REQ-026 IDLE SHALL go to RUN on start.
REQ-027 RUN SHALL go to DRAIN on drain.
REQ-028 DRAIN SHALL go to IDLE when all credit counters are 0, asserting drain_done for one cycle on that transition.
REQ-029 A requester i SHALL be eligible only when all of the following hold:
- state is RUN;
- q_full is 0;
- req_valid[i] is 1;
- req_we[i] is 1 or credit[i] < MAX_OUTSTANDING.
REQ-030 At most one req_ready bit SHALL be high per cycle: the first eligible requester at or after the round-robin pointer, searching upward with wrap-around.
REQ-031 req_ready, q_enq and q_data SHALL be combinational in the same cycle (zero latency), with q_enq = |(req_valid & req_ready).
REQ-032 After a grant to requester i, the pointer SHALL become (i+1) mod NUM_REQ; with no grant, the pointer SHALL hold.
REQ-033 A granted read SHALL increment credit[id]; writes SHALL NOT consume credit.
REQ-034 Credit counters SHALL be $clog2(MAX_OUTSTANDING+1) bits wide and SHALL saturate neither up nor down beyond their legal range.
REQ-035 On rsp_in_valid with credit[rsp_in_id] > 0, the block SHALL decrement the counter and, one cycle later (registered), pulse rsp_valid[rsp_in_id] with rsp_data = rsp_in_data.
REQ-036 Simultaneous grant-read and response for the same requester SHALL leave its counter unchanged.
REQ-037 A response with credit 0 SHALL be dropped, produce no rsp_valid, and set err.
REQ-038 Responses SHALL be accepted in every state, including IDLE.
REQ-039 start in RUN or DRAIN SHALL be ignored.
REQ-040 drain in IDLE or DRAIN SHALL be ignored.

Reset
REQ-041 reset SHALL force the following, overriding all other inputs:
- state = IDLE;
- pointer = 0;
- all credits = 0;
- rsp_valid = 0;
- rsp_data = 0;
- err = 0;
- drain_done = 0.
REQ-042 start from IDLE SHALL clear credits, pointer and err.
REQ-043 Reset asserted mid-operation SHALL discard in-flight credit state with no drain_done pulse.

Structure
REQ-044 A shared package SHALL hold the state enum and the q_data field offset/width constants, used by the DRAM-side unpacker.
REQ-045 The round-robin pick SHALL be one sub-module, rr_picker (inputs eligible vector and pointer; outputs one-hot grant and index).
REQ-046 The downstream queue SHALL be instantiated outside this block.

Verification
REQ-047 Contention: after start, hold all 4 req_valid high with writes and q_full=0 -> grants 0,1,2,3,0 on consecutive cycles, with q_enq high every cycle.
REQ-048 Backpressure: q_full=1 for 3 cycles with requests pending -> req_ready=0 and q_enq=0 throughout; the granting order resumes at the same pointer.
REQ-049 Credits: requester 2 issues 8 reads with no responses -> the 9th read is blocked while requester 2 writes are still granted; one response with id 2 -> rsp_valid=0100 the next cycle and the read is granted again.
REQ-050 Collision: a read grant and a response for requester 1 in the same cycle -> credit[1] is unchanged.
REQ-051 Drain: 3 reads outstanding, then drain -> no further grants; drain_done pulses one cycle after the 3rd response; busy=0 afterwards.
REQ-052 Error: a response with id 3 and credit 0 -> err=1, no rsp_valid; reset clears err.

Source files
------------

// File: rtl/mem_req_arbiter_pkg.sv
// Shared types and q_data field layout for the DRAM request arbiter and its
// downstream unpacker.
package mem_req_arbiter_pkg;

  typedef enum logic [1:0] {
    StIdle,
    StRun,
    StDrain
  } arb_state_e;

  // q_data = {id, we, addr, wdata}; wdata sits in the LSBs.
  function automatic int unsigned qd_id_width(input int unsigned num_req);
    return $clog2(num_req);
  endfunction

  function automatic int unsigned qd_wdata_lsb();
    return 0;
  endfunction

  function automatic int unsigned qd_addr_lsb(input int unsigned data_width);
    return data_width;
  endfunction

  function automatic int unsigned qd_we_bit(input int unsigned addr_width,
                                            input int unsigned data_width);
    return addr_width + data_width;
  endfunction

  function automatic int unsigned qd_id_lsb(input int unsigned addr_width,
                                            input int unsigned data_width);
    return addr_width + data_width + 1;
  endfunction

  function automatic int unsigned qd_width(input int unsigned num_req,
                                           input int unsigned addr_width,
                                           input int unsigned data_width);
    return qd_id_width(num_req) + 1 + addr_width + data_width;
  endfunction

  function automatic int unsigned credit_width(input int unsigned max_outstanding);
    return $clog2(max_outstanding + 1);
  endfunction

endpackage

// File: rtl/rr_picker.sv
// Round-robin picker: one-hot grant to the first eligible requester at or after
// the pointer, searching upward with wrap-around.
module rr_picker #(
  parameter int unsigned NUM_REQ = 4
) (
  input  logic [NUM_REQ-1:0]         eligible,
  input  logic [$clog2(NUM_REQ)-1:0] ptr,
  output logic [NUM_REQ-1:0]         grant,
  output logic [$clog2(NUM_REQ)-1:0] idx
);

  localparam int unsigned IdxW = $clog2(NUM_REQ);

  int unsigned      cand;
  logic [IdxW-1:0]  cand_idx;
  logic             found;

  always_comb begin
    grant    = '0;
    idx      = '0;
    found    = 1'b0;
    cand     = 0;
    cand_idx = '0;
    for (int unsigned k = 0; k < NUM_REQ; k++) begin
      cand     = (32'(ptr) + k) % NUM_REQ;
      cand_idx = IdxW'(cand);
      if (!found && eligible[cand_idx]) begin
        found           = 1'b1;
        grant[cand_idx] = 1'b1;
        idx             = cand_idx;
      end
    end
  end

endmodule

// File: rtl/mem_req_arbiter.sv
// Round-robin arbiter feeding one DRAM request queue, with per-requester read
// credits and a registered one-hot response demux.
module mem_req_arbiter
  import mem_req_arbiter_pkg::*;
#(
  parameter int unsigned NUM_REQ         = 4,
  parameter int unsigned ADDR_WIDTH      = 32,
  parameter int unsigned DATA_WIDTH      = 512,
  parameter int unsigned MAX_OUTSTANDING = 8
) (
  input  logic                                                 clk,
  input  logic                                                 reset,
  input  logic                                                 start,
  input  logic                                                 drain,
  input  logic [NUM_REQ-1:0]                                   req_valid,
  input  logic [NUM_REQ-1:0]                                   req_we,
  input  logic [NUM_REQ*ADDR_WIDTH-1:0]                        req_addr,
  input  logic [NUM_REQ*DATA_WIDTH-1:0]                        req_wdata,
  output logic [NUM_REQ-1:0]                                   req_ready,
  output logic                                                 q_enq,
  output logic [qd_width(NUM_REQ, ADDR_WIDTH, DATA_WIDTH)-1:0] q_data,
  input  logic                                                 q_full,
  input  logic                                                 rsp_in_valid,
  input  logic [$clog2(NUM_REQ)-1:0]                           rsp_in_id,
  input  logic [DATA_WIDTH-1:0]                                rsp_in_data,
  output logic [NUM_REQ-1:0]                                   rsp_valid,
  output logic [DATA_WIDTH-1:0]                                rsp_data,
  output logic                                                 busy,
  output logic                                                 drain_done,
  output logic                                                 err
);

  localparam int unsigned IdW = $clog2(NUM_REQ);
  localparam int unsigned CrW = credit_width(MAX_OUTSTANDING);
  localparam logic [CrW-1:0] CrMax = CrW'(MAX_OUTSTANDING);

  arb_state_e          state_q, state_d;
  logic [IdW-1:0]      ptr_q, ptr_d;
  logic [CrW-1:0]      credit_q [NUM_REQ];
  logic [CrW-1:0]      credit_d [NUM_REQ];
  logic [NUM_REQ-1:0]  rsp_valid_q;
  logic [DATA_WIDTH-1:0] rsp_data_q, rsp_data_d;
  logic                err_q, err_d;

  logic                start_job;
  logic                all_zero;
  logic [NUM_REQ-1:0]  eligible;
  logic [NUM_REQ-1:0]  grant;
  logic [IdW-1:0]      grant_idx;
  logic [NUM_REQ-1:0]  rd_grant;
  logic [NUM_REQ-1:0]  rsp_dec;
  logic                rsp_hit;

  logic [ADDR_WIDTH-1:0] addr_arr  [NUM_REQ];
  logic [DATA_WIDTH-1:0] wdata_arr [NUM_REQ];

  for (genvar g = 0; g < NUM_REQ; g++) begin : g_unpack
    assign addr_arr[g]  = req_addr[g*ADDR_WIDTH +: ADDR_WIDTH];
    assign wdata_arr[g] = req_wdata[g*DATA_WIDTH +: DATA_WIDTH];
  end

  assign start_job = (state_q == StIdle) && start;
  assign busy      = (state_q != StIdle);

  always_comb begin
    all_zero = 1'b1;
    for (int unsigned i = 0; i < NUM_REQ; i++) begin
      if (credit_q[i] != '0) all_zero = 1'b0;
    end
  end

  // Writes never wait on credit; reads stall once MAX_OUTSTANDING are in flight.
  always_comb begin
    eligible = '0;
    for (int unsigned i = 0; i < NUM_REQ; i++) begin
      eligible[i] = (state_q == StRun) && !q_full && req_valid[i] &&
                    (req_we[i] || (credit_q[i] < CrMax));
    end
  end

  rr_picker #(
    .NUM_REQ(NUM_REQ)
  ) u_picker (
    .eligible(eligible),
    .ptr     (ptr_q),
    .grant   (grant),
    .idx     (grant_idx)
  );

  assign req_ready = grant;
  assign q_enq     = |(req_valid & req_ready);
  assign rd_grant  = grant & ~req_we & {NUM_REQ{q_enq}};

  always_comb begin
    q_data = '0;
    q_data[qd_id_lsb(ADDR_WIDTH, DATA_WIDTH) +: IdW]      = grant_idx;
    q_data[qd_we_bit(ADDR_WIDTH, DATA_WIDTH)]             = req_we[grant_idx];
    q_data[qd_addr_lsb(DATA_WIDTH) +: ADDR_WIDTH]         = addr_arr[grant_idx];
    q_data[qd_wdata_lsb() +: DATA_WIDTH]                  = wdata_arr[grant_idx];
  end

  // A response is only honoured against an outstanding read; anything else is an error.
  always_comb begin
    rsp_dec = '0;
    for (int unsigned i = 0; i < NUM_REQ; i++) begin
      rsp_dec[i] = rsp_in_valid && (rsp_in_id == IdW'(i)) && (credit_q[i] != '0);
    end
  end

  assign rsp_hit = |rsp_dec;

  always_comb begin
    for (int unsigned i = 0; i < NUM_REQ; i++) begin
      credit_d[i] = credit_q[i];
      if (start_job) begin
        credit_d[i] = '0;
      end else if (rd_grant[i] && !rsp_dec[i]) begin
        credit_d[i] = credit_q[i] + 1'b1;
      end else if (rsp_dec[i] && !rd_grant[i]) begin
        credit_d[i] = credit_q[i] - 1'b1;
      end
    end
  end

  always_comb begin
    ptr_d = ptr_q;
    if (start_job) begin
      ptr_d = '0;
    end else if (q_enq) begin
      ptr_d = (grant_idx == IdW'(NUM_REQ - 1)) ? '0 : grant_idx + 1'b1;
    end
  end

  // A bad response arriving with start still latches, so it is never lost.
  always_comb begin
    err_d = err_q;
    if (start_job) err_d = 1'b0;
    if (rsp_in_valid && !rsp_hit) err_d = 1'b1;
  end

  assign rsp_data_d = rsp_hit ? rsp_in_data : rsp_data_q;

  always_comb begin
    state_d    = state_q;
    drain_done = 1'b0;
    case (state_q)
      StIdle: begin
        if (start) state_d = StRun;
      end
      StRun: begin
        if (drain) state_d = StDrain;
      end
      StDrain: begin
        if (all_zero) begin
          state_d    = StIdle;
          drain_done = !reset;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= StIdle;
      ptr_q       <= '0;
      rsp_valid_q <= '0;
      rsp_data_q  <= '0;
      err_q       <= 1'b0;
      for (int unsigned i = 0; i < NUM_REQ; i++) credit_q[i] <= '0;
    end else begin
      state_q     <= state_d;
      ptr_q       <= ptr_d;
      rsp_valid_q <= rsp_dec;
      rsp_data_q  <= rsp_data_d;
      err_q       <= err_d;
      for (int unsigned i = 0; i < NUM_REQ; i++) credit_q[i] <= credit_d[i];
    end
  end

  assign rsp_valid = rsp_valid_q;
  assign rsp_data  = rsp_data_q;
  assign err       = err_q;

endmodule

// File: tb/tb_mem_req_arbiter.sv
// Directed scoreboard bench for mem_req_arbiter: expected grants and responses are
// queued by the stimulus and consumed by a monitor whenever the DUT presents them.
module tb_mem_req_arbiter;

  localparam int NR = 4;
  localparam int AW = 32;
  localparam int DW = 512;
  localparam int QW = 2 + 1 + AW + DW;

  logic              clk = 1'b0;
  logic              reset, start, drain;
  logic [NR-1:0]     req_valid, req_we, req_ready;
  logic [NR*AW-1:0]  req_addr;
  logic [NR*DW-1:0]  req_wdata;
  logic              q_enq, q_full;
  logic [QW-1:0]     q_data;
  logic              rsp_in_valid;
  logic [1:0]        rsp_in_id;
  logic [DW-1:0]     rsp_in_data;
  logic [NR-1:0]     rsp_valid;
  logic [DW-1:0]     rsp_data;
  logic              busy, drain_done, err;

  typedef struct packed {
    logic [1:0]    id;
    logic          we;
    logic [AW-1:0] addr;
    logic [DW-1:0] wdata;
  } grant_t;

  typedef struct packed {
    logic [NR-1:0] oh;
    logic [DW-1:0] data;
  } rsp_t;

  grant_t gq[$];
  rsp_t   rq[$];
  int     total = 0;
  int     bad = 0;
  int     rsp_n = 0;

  always #5 clk = ~clk;

  mem_req_arbiter dut (
    .clk         (clk),
    .reset       (reset),
    .start       (start),
    .drain       (drain),
    .req_valid   (req_valid),
    .req_we      (req_we),
    .req_addr    (req_addr),
    .req_wdata   (req_wdata),
    .req_ready   (req_ready),
    .q_enq       (q_enq),
    .q_data      (q_data),
    .q_full      (q_full),
    .rsp_in_valid(rsp_in_valid),
    .rsp_in_id   (rsp_in_id),
    .rsp_in_data (rsp_in_data),
    .rsp_valid   (rsp_valid),
    .rsp_data    (rsp_data),
    .busy        (busy),
    .drain_done  (drain_done),
    .err         (err)
  );

  function automatic logic [AW-1:0] ad(input int i);
    return 32'h1000 + 32'(i) * 32'h100;
  endfunction

  function automatic logic [DW-1:0] wd(input int i);
    return {16{32'hC0DE_0000 | 32'(i)}};
  endfunction

  function automatic logic [DW-1:0] rd(input int n);
    return {16{32'hBEEF_0000 | 32'(n)}};
  endfunction

  task automatic chk(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", name, act, exp);
    end
  endtask

  task automatic to_neg();
    @(negedge clk);
  endtask

  task automatic to_pos();
    @(posedge clk);
    #1;
  endtask

  task automatic cyc();
    to_neg();
    to_pos();
  endtask

  task automatic exp_g(input int id, input logic we);
    grant_t g;
    g.id    = 2'(id);
    g.we    = we;
    g.addr  = ad(id);
    g.wdata = wd(id);
    gq.push_back(g);
  endtask

  task automatic drive_rsp(input int id);
    rsp_t r;
    rsp_in_valid = 1'b1;
    rsp_in_id    = 2'(id);
    rsp_in_data  = rd(rsp_n);
    r.oh         = 4'(1 << id);
    r.data       = rd(rsp_n);
    rq.push_back(r);
    rsp_n++;
  endtask

  task automatic monitor();
    grant_t eg;
    rsp_t   er;
    forever begin
      @(negedge clk);
      if (q_enq) begin
        if (gq.size() == 0) begin
          total++;
          bad++;
          $display("FAIL grant_unexpected: got id %0d want none", q_data[QW-1 -: 2]);
        end else begin
          eg = gq.pop_front();
          chk("grant_id", DW'(q_data[QW-1 -: 2]), DW'(eg.id));
          chk("grant_we", DW'(q_data[AW+DW]), DW'(eg.we));
          chk("grant_addr", DW'(q_data[DW +: AW]), DW'(eg.addr));
          chk("grant_wdata", q_data[DW-1:0], eg.wdata);
          chk("grant_ready", DW'(req_ready), DW'(4'b0001 << eg.id));
        end
      end
      if (rsp_valid != '0) begin
        if (rq.size() == 0) begin
          total++;
          bad++;
          $display("FAIL rsp_unexpected: got %b want none", rsp_valid);
        end else begin
          er = rq.pop_front();
          chk("rsp_onehot", DW'(rsp_valid), DW'(er.oh));
          chk("rsp_data", rsp_data, er.data);
        end
      end
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1);
  end

  initial begin
    reset = 1'b1; start = 1'b0; drain = 1'b0;
    req_valid = '1; req_we = '1; q_full = 1'b0;
    rsp_in_valid = 1'b0; rsp_in_id = '0; rsp_in_data = '0;
    for (int i = 0; i < NR; i++) begin
      req_addr[i*AW +: AW]  = ad(i);
      req_wdata[i*DW +: DW] = wd(i);
    end
    fork
      monitor();
    join_none

    // Reset state
    to_neg();
    chk("reset_busy", DW'(busy), DW'(0));
    chk("reset_err", DW'(err), DW'(0));
    chk("reset_rsp_valid", DW'(rsp_valid), DW'(0));
    chk("reset_rsp_data", rsp_data, DW'(0));
    chk("reset_drain_done", DW'(drain_done), DW'(0));
    chk("reset_enq", DW'(q_enq), DW'(0));
    to_pos();
    reset = 1'b0;

    // Start cycle: still IDLE, so no grant
    start = 1'b1;
    to_neg();
    chk("idle_no_grant", DW'(q_enq), DW'(0));
    to_pos();
    start = 1'b0;

    // Contention: all writes, grants rotate 0,1,2,3,0; start in RUN is ignored
    for (int k = 0; k < 5; k++) begin
      start = (k == 2);
      exp_g(k % 4, 1'b1);
      to_neg();
      chk("contention_enq", DW'(q_enq), DW'(1));
      chk("contention_busy", DW'(busy), DW'(1));
      to_pos();
    end
    start = 1'b0;

    // Backpressure: nothing granted while full, then resume at requester 1
    q_full = 1'b1;
    for (int k = 0; k < 3; k++) begin
      to_neg();
      chk("bp_ready", DW'(req_ready), DW'(0));
      chk("bp_enq", DW'(q_enq), DW'(0));
      to_pos();
    end
    q_full = 1'b0;
    exp_g(1, 1'b1); cyc();
    exp_g(2, 1'b1); cyc();

    // Credits: 8 reads from requester 2, then the 9th is blocked
    req_valid = 4'b0100;
    req_we    = 4'b0000;
    for (int k = 0; k < 8; k++) begin
      exp_g(2, 1'b0);
      cyc();
    end
    to_neg();
    chk("credit_block", DW'(q_enq), DW'(0));
    to_pos();
    req_we = 4'b0100;
    exp_g(2, 1'b1);
    to_neg();
    chk("credit_write_ok", DW'(q_enq), DW'(1));
    to_pos();
    req_we = 4'b0000;
    to_neg();
    chk("credit_block_again", DW'(q_enq), DW'(0));
    to_pos();
    drive_rsp(2);
    to_neg();
    chk("credit_block_rsp_cycle", DW'(q_enq), DW'(0));
    to_pos();
    rsp_in_valid = 1'b0;
    exp_g(2, 1'b0);
    to_neg();
    chk("credit_rsp_valid", DW'(rsp_valid), DW'(4'b0100));
    chk("credit_regrant", DW'(q_enq), DW'(1));
    to_pos();
    req_valid = '0;
    for (int k = 0; k < 8; k++) begin
      drive_rsp(2);
      cyc();
    end
    rsp_in_valid = 1'b0;
    cyc();

    // Collision: read grant and response for requester 1 together
    req_valid = 4'b0010;
    exp_g(1, 1'b0); cyc();
    exp_g(1, 1'b0); drive_rsp(1); cyc();
    req_valid = '0;
    drive_rsp(1); cyc();
    rsp_in_valid = 1'b0;
    to_neg();
    chk("collision_no_err", DW'(err), DW'(0));
    to_pos();

    // Drain: three reads outstanding (ids 3,0,1), then drain
    req_valid = 4'b1011;
    exp_g(3, 1'b0); cyc();
    exp_g(0, 1'b0); cyc();
    exp_g(1, 1'b0); cyc();
    req_valid = '0;
    drain = 1'b1;
    cyc();
    drain = 1'b0;
    req_valid = 4'b1011;
    start = 1'b1;
    to_neg();
    chk("drain_no_grant", DW'(q_enq), DW'(0));
    chk("drain_busy", DW'(busy), DW'(1));
    to_pos();
    start = 1'b0;
    to_neg();
    chk("drain_no_grant2", DW'(q_enq), DW'(0));
    to_pos();
    drive_rsp(3);
    to_neg();
    chk("drain_hold_enq", DW'(q_enq), DW'(0));
    chk("drain_done_early", DW'(drain_done), DW'(0));
    to_pos();
    drive_rsp(0); cyc();
    drive_rsp(1);
    to_neg();
    chk("drain_done_at_last_rsp", DW'(drain_done), DW'(0));
    to_pos();
    rsp_in_valid = 1'b0;
    to_neg();
    chk("drain_done_pulse", DW'(drain_done), DW'(1));
    to_pos();
    drain = 1'b1;
    to_neg();
    chk("drain_done_once", DW'(drain_done), DW'(0));
    chk("idle_busy", DW'(busy), DW'(0));
    chk("idle_enq", DW'(q_enq), DW'(0));
    to_pos();
    drain = 1'b0;
    to_neg();
    chk("drain_ignored_idle", DW'(busy), DW'(0));
    to_pos();
    req_valid = '0;

    // Error: response for id 3 with no credit, accepted while IDLE
    rsp_in_valid = 1'b1;
    rsp_in_id    = 2'd3;
    rsp_in_data  = rd(99);
    cyc();
    rsp_in_valid = 1'b0;
    to_neg();
    chk("err_set", DW'(err), DW'(1));
    chk("err_no_rsp", DW'(rsp_valid), DW'(0));
    to_pos();
    to_neg();
    chk("err_sticky", DW'(err), DW'(1));
    to_pos();
    reset = 1'b1;
    cyc();
    reset = 1'b0;
    to_neg();
    chk("err_reset_clear", DW'(err), DW'(0));
    to_pos();
    rsp_in_valid = 1'b1;
    cyc();
    rsp_in_valid = 1'b0;
    start = 1'b1;
    to_neg();
    chk("err_set_again", DW'(err), DW'(1));
    to_pos();
    start = 1'b0;
    to_neg();
    chk("start_clears_err", DW'(err), DW'(0));
    chk("start_busy", DW'(busy), DW'(1));
    to_pos();

    cyc();
    to_neg();
    chk("grant_queue_empty", DW'(gq.size()), DW'(0));
    chk("rsp_queue_empty", DW'(rq.size()), DW'(0));
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
